io_input_bank: RTL and testbench

Parametrised memory-mapped input port bank for the single-cycle CPU I/O subsystem. It samples `N_CH` external input channels of `CH_W` bits each through two-flop synchronisers and an optional debounce filter, then holds the stable values in registers. The CPU reads these registers through the I/O read path, decoded on `addr[7:2]`. Per-channel sticky change flags, readable through a status word and cleared on read, drive a level interrupt request.

---
 rtl/io_input_bank.sv | 116 +++++++++++
 tb/tb_io_input_bank.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_bank.sv
// Memory-mapped input port bank: synchronised (optionally debounced) input channels,
// sticky change flags with clear-on-read status word and level irq. Option macro: IO_INPUT_DEBOUNCE_EN.
module io_input_bank #(
   parameter int N_CH       = 2,
   parameter int CH_W       = 5,
   parameter int DEB_CYCLES = 4
) (
   input  logic                   io_clk,
   input  logic                   reset,
   input  logic [31:0]            addr,
   input  logic                   rd_en,
   input  logic [N_CH*CH_W-1:0]   in_pins,
   output logic [31:0]            io_read_data,
   output logic                   irq
);

   localparam logic [5:0] STATUS_IDX = 6'(N_CH);

   logic [N_CH-1:0][CH_W-1:0] sync1_r;
   logic [N_CH-1:0][CH_W-1:0] sync2_r;
   logic [N_CH-1:0][CH_W-1:0] stable_r;
   logic [N_CH-1:0][CH_W-1:0] stable_nxt_s;
   logic [N_CH-1:0]           flags_r;
   logic [N_CH-1:0]           flags_nxt_s;
   logic [N_CH-1:0]           set_s;
   logic                      irq_r;
   logic [5:0]                word_idx_s;
   logic                      clr_s;
   logic [31:0]               rd_data_s;
   logic                      addr_unused_s;

   assign word_idx_s    = addr[7:2];
   assign addr_unused_s = ^{addr[31:8], addr[1:0], 8'(DEB_CYCLES)};

`ifdef IO_INPUT_DEBOUNCE_EN
   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

   logic [N_CH-1:0][7:0] cnt_r;
   logic [N_CH-1:0][7:0] cnt_nxt_s;

   // Debounce qualification: any mismatch must persist DEB_CYCLES edges before it is accepted.
   always_comb begin
      stable_nxt_s = stable_r;
      cnt_nxt_s    = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sync2_r[i] == stable_r[i]) begin
            cnt_nxt_s[i] = 8'h00;
         end else if (cnt_r[i] == DEB_LAST) begin
            stable_nxt_s[i] = sync2_r[i];
            cnt_nxt_s[i]    = 8'h00;
         end else begin
            cnt_nxt_s[i] = cnt_r[i] + 8'h01;
         end
      end
   end

   // Debounce counter state.
   always_ff @(posedge io_clk or posedge reset) begin
      if (reset) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end
`else
   // Without debounce the stable register simply follows the synchroniser output.
   always_comb begin
      stable_nxt_s = sync2_r;
   end
`endif

   // Change detection and sticky flags; a set on the clearing edge wins over the clear.
   always_comb begin
      clr_s = rd_en && (word_idx_s == STATUS_IDX);
      set_s = '0;
      for (int i = 0; i < N_CH; i++) begin
         set_s[i] = (stable_nxt_s[i] != stable_r[i]);
      end
      flags_nxt_s = (flags_r & ~{N_CH{clr_s}}) | set_s;
   end

   // Synchronisers, stable registers, flags and interrupt request.
   always_ff @(posedge io_clk or posedge reset) begin
      if (reset) begin
         sync1_r  <= '0;
         sync2_r  <= '0;
         stable_r <= '0;
         flags_r  <= '0;
         irq_r    <= 1'b0;
      end else begin
         sync1_r  <= in_pins;
         sync2_r  <= sync1_r;
         stable_r <= stable_nxt_s;
         flags_r  <= flags_nxt_s;
         irq_r    <= |flags_nxt_s;
      end
   end

   // Read mux: one-hot word selection OR-ed together, zero for unmapped words.
   always_comb begin
      logic [31:0] word_s;
      rd_data_s = 32'h0000_0000;
      for (int i = 0; i < N_CH; i++) begin
         word_s             = 32'h0000_0000;
         word_s[CH_W-1:0]   = stable_r[i];
         rd_data_s          = rd_data_s | (word_s & {32{word_idx_s == 6'(i)}});
      end
      word_s           = 32'h0000_0000;
      word_s[N_CH-1:0] = flags_r;
      rd_data_s        = rd_data_s | (word_s & {32{word_idx_s == STATUS_IDX}});
   end

   assign io_read_data = rd_data_s;
   assign irq          = irq_r;

endmodule

// File: tb/tb_io_input_bank.sv
// Directed self-checking bench for io_input_bank (N_CH=2, CH_W=5, DEB_CYCLES=4).
module tb_io_input_bank;

   localparam int N_CH = 2;
   localparam int CH_W = 5;
   localparam int DEB  = 4;
`ifdef IO_INPUT_DEBOUNCE_EN
   localparam int LAT = 2 + DEB;
`else
   localparam int LAT = 3;
`endif

   logic                 io_clk;
   logic                 reset;
   logic [31:0]          addr;
   logic                 rd_en;
   logic [N_CH*CH_W-1:0] in_pins;
   logic [31:0]          io_read_data;
   logic                 irq;

   int checks;
   int errors;

   io_input_bank #(.N_CH(N_CH), .CH_W(CH_W), .DEB_CYCLES(DEB)) dut (
      .io_clk       (io_clk),
      .reset        (reset),
      .addr         (addr),
      .rd_en        (rd_en),
      .in_pins      (in_pins),
      .io_read_data (io_read_data),
      .irq          (irq)
   );

   initial io_clk = 1'b0;
   always #5 io_clk = ~io_clk;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge io_clk);
         #1;
      end
   endtask

   task automatic set_word(input int w);
      addr = 32'(w) << 2;
      #1;
   endtask

   task automatic clear_flags();
      set_word(2);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      in_pins = '1;
      tick(2);
      reset = 1'b0;
      tick(LAT + 2);
      #2;
      reset = 1'b1;
      #1;
      for (int w = 0; w < 3; w++) begin
         set_word(w);
         checks++;
         if (io_read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_read_w%0d: got %h expected %h", w, io_read_data, 32'h0);
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
      @(negedge io_clk);
      reset = 1'b0;
      set_word(0);
      tick(LAT - 1);
      checks++;
      if (io_read_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_latency_early: got %h expected %h", io_read_data, 32'h0);
      end
      tick(1);
      checks++;
      if (io_read_data !== 32'h1F || irq !== 1'b1) begin
         errors++;
         $display("FAIL reset_latency_value: got %h irq %b expected %h irq 1", io_read_data, irq, 32'h1F);
      end
   endtask

   task automatic test_map();
      clear_flags();
      in_pins = {5'h0A, 5'h15};
      tick(LAT + 1);
      set_word(0);
      checks++;
      if (io_read_data !== 32'h15) begin
         errors++;
         $display("FAIL map_w0: got %h expected %h", io_read_data, 32'h15);
      end
      set_word(1);
      checks++;
      if (io_read_data !== 32'h0A) begin
         errors++;
         $display("FAIL map_w1: got %h expected %h", io_read_data, 32'h0A);
      end
      addr = 32'hFFFF_FF07;
      #1;
      checks++;
      if (io_read_data !== 32'h0A) begin
         errors++;
         $display("FAIL map_w1_upper_bits: got %h expected %h", io_read_data, 32'h0A);
      end
      set_word(2);
      checks++;
      if (io_read_data !== 32'h3) begin
         errors++;
         $display("FAIL map_status: got %h expected %h", io_read_data, 32'h3);
      end
      set_word(3);
      checks++;
      if (io_read_data !== 32'h0) begin
         errors++;
         $display("FAIL map_w3: got %h expected %h", io_read_data, 32'h0);
      end
      set_word(63);
      checks++;
      if (io_read_data !== 32'h0) begin
         errors++;
         $display("FAIL map_w63: got %h expected %h", io_read_data, 32'h0);
      end
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL map_irq: got %b expected 1", irq);
      end
   endtask

   task automatic test_clear_on_read();
      set_word(0);
      rd_en = 1'b1;
      tick(1);
      set_word(2);
      rd_en = 1'b0;
      tick(1);
      checks++;
      if (io_read_data !== 32'h3 || irq !== 1'b1) begin
         errors++;
         $display("FAIL status_no_rd_en: got %h irq %b expected %h irq 1", io_read_data, irq, 32'h3);
      end
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      checks++;
      if (io_read_data !== 32'h0) begin
         errors++;
         $display("FAIL clear_on_read_flags: got %h expected %h", io_read_data, 32'h0);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL clear_on_read_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_set_beats_clear();
      in_pins = {5'h0A, 5'h1B};
      tick(LAT - 1);
      set_word(0);
      checks++;
      if (io_read_data !== 32'h15) begin
         errors++;
         $display("FAIL sbc_before_edge: got %h expected %h", io_read_data, 32'h15);
      end
      set_word(2);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      checks++;
      if (io_read_data !== 32'h1 || irq !== 1'b1) begin
         errors++;
         $display("FAIL sbc_flag0: got %h irq %b expected %h irq 1", io_read_data, irq, 32'h1);
      end
      set_word(0);
      checks++;
      if (io_read_data !== 32'h1B) begin
         errors++;
         $display("FAIL sbc_value: got %h expected %h", io_read_data, 32'h1B);
      end
      clear_flags();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL sbc_final_clear: got %b expected 0", irq);
      end
   endtask

`ifdef IO_INPUT_DEBOUNCE_EN
   task automatic test_debounce();
      in_pins = {5'h0B, 5'h1B};
      tick(3);
      in_pins = {5'h0A, 5'h1B};
      tick(8);
      set_word(1);
      checks++;
      if (io_read_data !== 32'h0A) begin
         errors++;
         $display("FAIL glitch_value: got %h expected %h", io_read_data, 32'h0A);
      end
      set_word(2);
      checks++;
      if (io_read_data !== 32'h0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL glitch_flag: got %h irq %b expected 0 irq 0", io_read_data, irq);
      end
      in_pins = {5'h0B, 5'h1B};
      set_word(1);
      tick(LAT - 1);
      checks++;
      if (io_read_data !== 32'h0A) begin
         errors++;
         $display("FAIL held_early: got %h expected %h", io_read_data, 32'h0A);
      end
      tick(1);
      checks++;
      if (io_read_data !== 32'h0B) begin
         errors++;
         $display("FAIL held_edge6: got %h expected %h", io_read_data, 32'h0B);
      end
      set_word(2);
      checks++;
      if (io_read_data !== 32'h2) begin
         errors++;
         $display("FAIL held_flag1: got %h expected %h", io_read_data, 32'h2);
      end
      clear_flags();
   endtask

   task automatic test_reset_mid_debounce();
      in_pins = {5'h0B, 5'h04};
      tick(4);
      #2;
      reset = 1'b1;
      @(negedge io_clk);
      reset = 1'b0;
      set_word(2);
      tick(DEB + 1);
      checks++;
      if (io_read_data !== 32'h0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_early_flag: got %h irq %b expected 0 irq 0", io_read_data, irq);
      end
      set_word(0);
      checks++;
      if (io_read_data !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_early_value: got %h expected %h", io_read_data, 32'h0);
      end
      tick(1);
      checks++;
      if (io_read_data !== 32'h04 || irq !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_value: got %h irq %b expected %h irq 1", io_read_data, irq, 32'h04);
      end
   endtask
`endif

   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      addr    = 32'h0;
      rd_en   = 1'b0;
      in_pins = '0;
      test_reset();
      test_map();
      test_clear_on_read();
      test_set_beats_clear();
`ifdef IO_INPUT_DEBOUNCE_EN
      test_debounce();
      test_reset_mid_debounce();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
